systolic_result_drain: RTL

//  Unload end of the PE array's mac_out result chain. On request it loads every PE's accumulator

---
 rtl/systolic_result_drain_if.sv | 40 ++++
 rtl/systolic_result_drain.sv | 135 +++++++++++++
 2 files changed

// File: rtl/systolic_result_drain_if.sv
// ----------------------------------------------------------------------------
// systolic_result_drain_if
//   Bundles the drain block's start handshake, PE chain control, chain input
//   and output stream into one interface.
//   master : the drain block (drives start_ready, PE control, output stream)
//   slave  : the surrounding logic (drives start request, chain_in, out_ready)
// Signals
//   start_valid/start_ready/relu_en/clear_acc : tile drain request
//   write_out_en/reset_pe                     : broadcast PE control
//   chain_in                                  : bottom-row mac_out, col c at [c*DW +: DW]
//   out_data/out_valid/out_ready/out_last     : row stream, same column packing
//   busy                                      : FSM not idle
// ----------------------------------------------------------------------------
interface systolic_result_drain_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 8
);
    logic                          start_valid;
    logic                          start_ready;
    logic                          relu_en;
    logic                          clear_acc;
    logic                          write_out_en;
    logic                          reset_pe;
    logic [NUM_COL*DATA_WIDTH-1:0] chain_in;
    logic [NUM_COL*DATA_WIDTH-1:0] out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic                          busy;

    modport master (
        input  start_valid, relu_en, clear_acc, chain_in, out_ready,
        output start_ready, write_out_en, reset_pe, out_data, out_valid, out_last, busy
    );

    modport slave (
        output start_valid, relu_en, clear_acc, chain_in, out_ready,
        input  start_ready, write_out_en, reset_pe, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/systolic_result_drain.sv
// ----------------------------------------------------------------------------
// systolic_result_drain
//   Unloads the PE array's mac_out chain. A tile drain copies every PE result
//   into mac_out (LOAD), optionally clears the accumulators on the same edge,
//   then shifts the chain NUM_ROW times (SHIFT), pushing each bottom-row word
//   (optionally ReLU'd) into a capture FIFO. The FIFO streams rows out on a
//   valid/ready port; the shift never stalls because a tile is only accepted
//   when NUM_ROW free entries exist.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : systolic_result_drain_if.master (handshake, PE control, stream)
// ----------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 8,
    parameter int NUM_COL    = 8,
    parameter int FIFO_DEPTH = 2*NUM_ROW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    systolic_result_drain_if.master       bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int KW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam int WW = NUM_COL*DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t                              r_state, w_state_nxt;
    logic [KW-1:0]                       r_k;
    logic                                r_relu, r_clear;
    logic                                r_live;       // low through reset so start_ready reads 0
    logic [PW:0]                         r_count;
    logic [PW-1:0]                       r_wptr, r_rptr;
    logic [WW:0]                         r_mem [FIFO_DEPTH];  // {last, word}

    logic                                w_last_k, w_space_ok, w_push, w_pop, w_accept;
    logic                                w_start_ready, w_weo, w_rpe;
    logic [NUM_COL-1:0][DATA_WIDTH-1:0]  w_word;
    logic [WW:0]                         w_head;

    assign w_last_k   = (r_k == KW'(NUM_ROW-1));
    assign w_space_ok = (r_count <= (PW+1)'(FIFO_DEPTH - NUM_ROW));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_ready = 1'b0;
        w_weo         = 1'b0;
        w_rpe         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_ready = r_live && w_space_ok;
                if (bus.start_valid && w_start_ready) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_rpe       = r_clear;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_weo = 1'b1;
                if (w_last_k) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && bus.start_valid && w_start_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_relu  <= 1'b0;
            r_clear <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_relu  <= bus.relu_en;
                r_clear <= bus.clear_acc;
            end
            if (r_state == S_LOAD)       r_k <= '0;
            else if (r_state == S_SHIFT) r_k <= r_k + KW'(1);
        end
    end

    assign bus.start_ready  = w_start_ready;
    assign bus.write_out_en = w_weo;
    assign bus.reset_pe     = w_rpe;
    assign bus.busy         = (r_state != S_IDLE);

    // ---------------- per-column ReLU on the pushed word ----------------
    for (genvar c = 0; c < NUM_COL; c++) begin : g_relu
        logic [DATA_WIDTH-1:0] w_elem;
        assign w_elem    = bus.chain_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_word[c] = (r_relu && w_elem[DATA_WIDTH-1]) ? '0 : w_elem;
    end

    // ---------------- capture FIFO (first-word-fall-through) ----------------
    assign w_push = (r_state == S_SHIFT);
    assign w_pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_last_k, w_word};
    end

    assign w_head        = r_mem[r_rptr];
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = bus.out_valid ? w_head[WW-1:0] : '0;
    assign bus.out_last  = bus.out_valid && w_head[WW];

    // The start space check makes a push into a full FIFO unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == (PW+1)'(FIFO_DEPTH))));

endmodule
